// File: rtl/ysyx_22040895_wbu.sv
// Write-back unit: LSU/EXU arbitration, load alignment and extension, registered GPR write port,
// pending-write scoreboard for decode hazards, and a retired-result counter.
module ysyx_22040895_wbu #(
   parameter int unsigned XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            issue_valid_i,
   input  logic            issue_wen_i,
   input  logic [4:0]      issue_rd_i,
   input  logic [4:0]      rs1_addr_i,
   input  logic [4:0]      rs2_addr_i,
   output logic            stall_o,
   input  logic            exu_valid_i,
   output logic            exu_ready_o,
   input  logic [4:0]      exu_rd_i,
   input  logic [XLEN-1:0] exu_result_i,
   input  logic            lsu_valid_i,
   output logic            lsu_ready_o,
   input  logic [4:0]      lsu_rd_i,
   input  logic [XLEN-1:0] lsu_rdata_i,
   input  logic [2:0]      lsu_funct3_i,
   input  logic [2:0]      lsu_addr_lo_i,
   output logic            we_o,
   output logic [4:0]      waddr_o,
   output logic [XLEN-1:0] wdata_o,
   output logic            load_err_o,
   output logic [63:0]     retire_cnt_o
);

   logic            lsu_fire, exu_fire, fire, set_en;
   logic [4:0]      sel_rd;
   logic [XLEN-1:0] shifted, load_data, sel_data;
   logic [31:0]     busy_q, busy_d;
   logic            we_q, err_q;
   logic [4:0]      waddr_q;
   logic [XLEN-1:0] wdata_q;
   logic [63:0]     cnt_q;

   // LSU has fixed priority; the EXU only moves when no load is offered.
   assign lsu_ready_o = 1'b1;
   assign exu_ready_o = ~lsu_valid_i;
   assign lsu_fire    = lsu_valid_i;
   assign exu_fire    = exu_valid_i & ~lsu_valid_i;
   assign fire        = lsu_fire | exu_fire;

   assign shifted = lsu_rdata_i >> {lsu_addr_lo_i, 3'b000};

   always_comb begin
      load_data = '0;
      case (lsu_funct3_i)
         3'b000:  load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         3'b001:  load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         3'b010:  load_data = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
         3'b011:  load_data = shifted;
         3'b100:  load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
         3'b101:  load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
         3'b110:  load_data = {{(XLEN-32){1'b0}}, shifted[31:0]};
         default: load_data = '0;
      endcase
   end

   assign sel_rd   = lsu_fire ? lsu_rd_i : exu_rd_i;
   assign sel_data = lsu_fire ? load_data : exu_result_i;

   assign stall_o = busy_q[rs1_addr_i] | busy_q[rs2_addr_i] | (issue_wen_i & busy_q[issue_rd_i]);
   assign set_en  = issue_valid_i & issue_wen_i & ~stall_o & (issue_rd_i != 5'd0);

   // Clear first, then set, so a same-cycle set on the retiring register wins.
   always_comb begin
      busy_d = busy_q;
      if (we_q) busy_d[waddr_q] = 1'b0;
      if (set_en) busy_d[issue_rd_i] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q  <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         busy_q <= busy_d;
         we_q   <= fire & (sel_rd != 5'd0);
         if (fire) begin
            waddr_q <= sel_rd;
            wdata_q <= sel_data;
            cnt_q   <= cnt_q + 64'd1;
         end
         if (lsu_fire && lsu_funct3_i == 3'b111) err_q <= 1'b1;
      end
   end

   assign we_o         = we_q;
   assign waddr_o      = waddr_q;
   assign wdata_o      = wdata_q;
   assign load_err_o   = err_q;
   assign retire_cnt_o = cnt_q;

endmodule

// File: tb/tb_ysyx_22040895_wbu.sv
// Self-checking bench for ysyx_22040895_wbu: directed scenarios then random traffic,
// all compared against a behavioural model of the write-back rules.
module tb_ysyx_22040895_wbu;

   logic        clk, rst;
   logic        issue_valid_i, issue_wen_i;
   logic [4:0]  issue_rd_i, rs1_addr_i, rs2_addr_i;
   logic        stall_o;
   logic        exu_valid_i, exu_ready_o;
   logic [4:0]  exu_rd_i;
   logic [63:0] exu_result_i;
   logic        lsu_valid_i, lsu_ready_o;
   logic [4:0]  lsu_rd_i;
   logic [63:0] lsu_rdata_i;
   logic [2:0]  lsu_funct3_i, lsu_addr_lo_i;
   logic        we_o;
   logic [4:0]  waddr_o;
   logic [63:0] wdata_o;
   logic        load_err_o;
   logic [63:0] retire_cnt_o;

   ysyx_22040895_wbu #(.XLEN(64)) dut (
      .clk(clk), .rst(rst),
      .issue_valid_i(issue_valid_i), .issue_wen_i(issue_wen_i), .issue_rd_i(issue_rd_i),
      .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .stall_o(stall_o),
      .exu_valid_i(exu_valid_i), .exu_ready_o(exu_ready_o), .exu_rd_i(exu_rd_i),
      .exu_result_i(exu_result_i),
      .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_rd_i(lsu_rd_i),
      .lsu_rdata_i(lsu_rdata_i), .lsu_funct3_i(lsu_funct3_i), .lsu_addr_lo_i(lsu_addr_lo_i),
      .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
      .load_err_o(load_err_o), .retire_cnt_o(retire_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference state
   bit          m_known = 0;
   bit          m_busy[32];
   bit          m_we, m_err;
   logic [4:0]  m_waddr;
   logic [63:0] m_wdata, m_cnt;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
      else n_pass++;
   endtask

   function automatic logic [63:0] load_ref(logic [63:0] raw, logic [2:0] lo, logic [2:0] f3);
      logic [63:0] s;
      byte         b;
      shortint     h;
      int          w;
      s = raw >> (lo * 8);
      b = s[7:0];
      h = s[15:0];
      w = s[31:0];
      case (f3)
         3'd0:    return longint'(b);
         3'd1:    return longint'(h);
         3'd2:    return longint'(w);
         3'd3:    return s;
         3'd4:    return s & 64'hFF;
         3'd5:    return s & 64'hFFFF;
         3'd6:    return s & 64'hFFFF_FFFF;
         default: return 64'd0;
      endcase
   endfunction

   function automatic bit model_stall();
      return m_busy[rs1_addr_i] || m_busy[rs2_addr_i] || (issue_wen_i && m_busy[issue_rd_i]);
   endfunction

   task automatic model_edge();
      bit          st, fire;
      logic [4:0]  rd;
      logic [63:0] d;
      if (rst) begin
         foreach (m_busy[i]) m_busy[i] = 0;
         m_we = 0; m_waddr = 0; m_wdata = 0; m_err = 0; m_cnt = 0;
         m_known = 1;
      end else begin
         st = model_stall();
         fire = 0; rd = 0; d = 0;
         if (lsu_valid_i) begin
            fire = 1; rd = lsu_rd_i;
            d = load_ref(lsu_rdata_i, lsu_addr_lo_i, lsu_funct3_i);
            if (lsu_funct3_i == 3'd7) m_err = 1;
         end else if (exu_valid_i) begin
            fire = 1; rd = exu_rd_i; d = exu_result_i;
         end
         if (m_we) m_busy[m_waddr] = 0;
         if (issue_valid_i && issue_wen_i && !st && issue_rd_i != 0) m_busy[issue_rd_i] = 1;
         m_we = fire && rd != 0;
         if (fire) begin
            m_waddr = rd; m_wdata = d; m_cnt = m_cnt + 1;
         end
      end
   endtask

   // Inputs are applied just after a falling edge; combinational outputs are checked mid-cycle,
   // registered outputs on the following falling edge.
   task automatic tick();
      #1;
      check("lsu_ready", lsu_ready_o, 1);
      check("exu_ready", exu_ready_o, !lsu_valid_i);
      if (m_known) check("stall", stall_o, model_stall());
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("we", we_o, m_we);
      check("waddr", waddr_o, m_waddr);
      check("wdata", wdata_o, m_wdata);
      check("load_err", load_err_o, m_err);
      check("retire_cnt", retire_cnt_o, m_cnt);
   endtask

   task automatic idle();
      rst = 0; issue_valid_i = 0; issue_wen_i = 0; issue_rd_i = 0;
      rs1_addr_i = 0; rs2_addr_i = 0;
      exu_valid_i = 0; exu_rd_i = 0; exu_result_i = 0;
      lsu_valid_i = 0; lsu_rd_i = 0; lsu_rdata_i = 0; lsu_funct3_i = 0; lsu_addr_lo_i = 0;
   endtask

   initial begin
      idle();
      rst = 1; lsu_valid_i = 1; lsu_rd_i = 9; lsu_rdata_i = 64'h55;
      @(negedge clk);
      tick();
      check("rst_we", we_o, 0);
      check("rst_cnt", retire_cnt_o, 0);
      tick();
      check("rst_stall", stall_o, 0);

      idle();
      exu_valid_i = 1; exu_rd_i = 5; exu_result_i = 64'h1234;
      tick();
      check("alu_wdata", wdata_o, 64'h1234);
      check("alu_cnt", retire_cnt_o, 1);

      idle();
      lsu_valid_i = 1; lsu_rd_i = 6; lsu_rdata_i = 64'h80FF_0000_0000_0000; lsu_addr_lo_i = 7;
      lsu_funct3_i = 3'b000;
      tick();
      check("lb_wdata", wdata_o, 64'hFFFF_FFFF_FFFF_FF80);
      lsu_funct3_i = 3'b100;
      tick();
      check("lbu_wdata", wdata_o, 64'h80);
      lsu_funct3_i = 3'b111;
      tick();
      check("bad_f3_wdata", wdata_o, 0);
      idle();
      tick();
      check("err_sticky", load_err_o, 1);

      lsu_valid_i = 1; lsu_rd_i = 3; lsu_rdata_i = 64'h11; lsu_funct3_i = 3'b011;
      exu_valid_i = 1; exu_rd_i = 4; exu_result_i = 64'h44;
      tick();
      check("conflict_lsu_first", waddr_o, 3);
      lsu_valid_i = 0;
      tick();
      check("conflict_exu_next", waddr_o, 4);

      idle();
      issue_valid_i = 1; issue_wen_i = 1; issue_rd_i = 7;
      tick();
      idle();
      rs1_addr_i = 7;
      #1 check("raw_stall", stall_o, 1);
      tick();
      exu_valid_i = 1; exu_rd_i = 7; exu_result_i = 64'h77;
      tick();
      exu_valid_i = 0;
      #1 check("stall_n1", stall_o, 1);
      tick();
      #1 check("stall_n2", stall_o, 0);
      tick();

      exu_valid_i = 1; exu_rd_i = 7; exu_result_i = 64'h78; rs1_addr_i = 0;
      tick();
      idle();
      issue_valid_i = 1; issue_wen_i = 1; issue_rd_i = 7;
      tick();
      idle();
      rs1_addr_i = 7;
      #1 check("set_wins", stall_o, 1);
      tick();

      idle();
      exu_valid_i = 1; exu_rd_i = 0; exu_result_i = 64'hDEAD;
      tick();
      check("x0_we", we_o, 0);
      idle();
      issue_valid_i = 1; issue_wen_i = 1; issue_rd_i = 0;
      tick();
      idle();
      issue_wen_i = 1;
      #1 check("x0_no_stall", stall_o, 0);
      tick();

      for (int i = 0; i < 3000; i++) begin
         rst           = ($urandom_range(0, 199) == 0);
         issue_valid_i = $urandom_range(0, 1);
         issue_wen_i   = $urandom_range(0, 1);
         issue_rd_i    = 5'($urandom_range(0, 7));
         rs1_addr_i    = 5'($urandom_range(0, 7));
         rs2_addr_i    = 5'($urandom_range(0, 7));
         exu_valid_i   = ($urandom_range(0, 9) < 6);
         exu_rd_i      = 5'($urandom_range(0, 7));
         exu_result_i  = {$urandom, $urandom};
         lsu_valid_i   = ($urandom_range(0, 9) < 3);
         lsu_rd_i      = 5'($urandom_range(0, 7));
         lsu_rdata_i   = {$urandom, $urandom};
         lsu_funct3_i  = 3'($urandom_range(0, 7));
         lsu_addr_lo_i = 3'($urandom_range(0, 7));
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
